// File: rtl/piarb_asa_wr_pkg.sv
// Shared types for the PIARB->ASA metadata write path: metadata word and
// write-master FSM states.
package piarb_asa_wr_pkg;

   localparam int META_W = 16;

   typedef logic [META_W-1:0] piarb_asa_meta_type;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } piarb_asa_wr_state_e;

endpackage

// File: rtl/rr_arb_1hot.sv
// Combinational rotating-priority arbiter: the first requester at or after
// ptr_i (mod NUM_SRC) wins, returned both one-hot and as an index.
module rr_arb_1hot #(
   parameter int NUM_SRC   = 4,
   parameter int SRC_NBITS = 2
) (
   input  logic [NUM_SRC-1:0]   req_i,
   input  logic [SRC_NBITS-1:0] ptr_i,
   output logic [NUM_SRC-1:0]   gnt_o,
   output logic [SRC_NBITS-1:0] gnt_idx_o,
   output logic                 vld_o
);

   int idx;

   // Walk from the farthest offset back to ptr_i so the nearest requester
   // is the last (winning) assignment.
   always_comb begin
      gnt_o     = '0;
      gnt_idx_o = '0;
      vld_o     = 1'b0;
      idx       = 0;
      for (int k = NUM_SRC - 1; k >= 0; k--) begin
         idx = (int'(ptr_i) + k) % NUM_SRC;
         if (req_i[idx]) begin
            gnt_o      = '0;
            gnt_o[idx] = 1'b1;
            gnt_idx_o  = SRC_NBITS'(idx);
            vld_o      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sfifo_piarb_asa.sv
// PIARB->ASA metadata FIFO: synchronous, first-word-fall-through, with full
// and full-minus-one flags for a registered write master.
module sfifo_piarb_asa
   import piarb_asa_wr_pkg::*;
#(
   parameter int DEPTH_NBITS = 3
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   wr_i,
   input  logic [META_W-1:0]      din_i,
   input  logic                   rd_i,
   output logic [META_W-1:0]      dout_o,
   output logic                   full_o,
   output logic                   fullm1_o,
   output logic                   empty_o,
   output logic [DEPTH_NBITS:0]   cnt_o
);

   localparam int DEPTH = 1 << DEPTH_NBITS;

   piarb_asa_meta_type       mem_q [DEPTH];
   logic [DEPTH_NBITS-1:0]   wptr_q, rptr_q;
   logic [DEPTH_NBITS:0]     cnt_q;
   logic                     do_wr, do_rd;

   assign full_o   = (cnt_q == (DEPTH_NBITS+1)'(DEPTH));
   assign fullm1_o = (cnt_q == (DEPTH_NBITS+1)'(DEPTH - 1));
   assign empty_o  = (cnt_q == '0);
   assign cnt_o    = cnt_q;
   assign dout_o   = mem_q[rptr_q];
   assign do_wr    = wr_i & ~full_o;
   assign do_rd    = rd_i & ~empty_o;

   always_ff @(posedge clk_i) begin
      if (do_wr) mem_q[wptr_q] <= din_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (do_wr) wptr_q <= wptr_q + 1'b1;
         if (do_rd) rptr_q <= rptr_q + 1'b1;
         if (do_wr && !do_rd)      cnt_q <= cnt_q + 1'b1;
         else if (do_rd && !do_wr) cnt_q <= cnt_q - 1'b1;
      end
   end

endmodule

// File: rtl/piarb_asa_wr.sv
// Write-side master for the PIARB->ASA metadata FIFO: round-robin over the
// metadata sources, one registered write per cycle, never onto a full FIFO.
module piarb_asa_wr
   import piarb_asa_wr_pkg::*;
#(
   parameter int NUM_SRC   = 4,
   parameter int SRC_NBITS = 2,
   parameter int CNT_NBITS = 32
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        en_i,
   input  logic [NUM_SRC-1:0]          src_valid_i,
   input  logic [NUM_SRC*META_W-1:0]   src_meta_i,
   output logic [NUM_SRC-1:0]          src_ready_o,
   input  logic                        fifo_full_i,
   input  logic                        fifo_fullm1_i,
   output logic                        fifo_wr_o,
   output logic [META_W-1:0]           fifo_din_o,
   output logic [SRC_NBITS-1:0]        fifo_src_o,
   output logic                        idle_o,
   output logic [CNT_NBITS-1:0]        wr_cnt_o,
   output logic                        ovf_err_o
);

   piarb_asa_wr_state_e     state_q, state_d;
   logic [SRC_NBITS-1:0]    rr_ptr_q, rr_ptr_d;
   logic                    fifo_wr_q;
   piarb_asa_meta_type      fifo_din_q;
   logic [SRC_NBITS-1:0]    fifo_src_q;
   logic [CNT_NBITS-1:0]    wr_cnt_q;
   logic                    ovf_err_q;

   logic [NUM_SRC-1:0]      gnt;
   logic [SRC_NBITS-1:0]    gnt_idx;
   logic                    gnt_vld;
   logic                    space, grant_ok, xfer;

   rr_arb_1hot #(
      .NUM_SRC   (NUM_SRC),
      .SRC_NBITS (SRC_NBITS)
   ) u_arb (
      .req_i     (src_valid_i),
      .ptr_i     (rr_ptr_q),
      .gnt_o     (gnt),
      .gnt_idx_o (gnt_idx),
      .vld_o     (gnt_vld)
   );

   // The write already in flight will land next edge, so it is charged
   // against the last free slot.
   assign space       = ~fifo_full_i & ~(fifo_fullm1_i & fifo_wr_q);
   assign grant_ok    = (state_q == ST_RUN) & space;
   assign src_ready_o = gnt & {NUM_SRC{grant_ok}};
   assign xfer        = grant_ok & gnt_vld;
   assign rr_ptr_d    = (gnt_idx == SRC_NBITS'(NUM_SRC - 1)) ? '0 : gnt_idx + 1'b1;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (en_i) state_d = ST_RUN;
         ST_RUN:   if (!en_i) state_d = ST_DRAIN;
         ST_DRAIN: begin
            if (en_i)            state_d = ST_RUN;
            else if (!fifo_wr_q) state_d = ST_IDLE;
         end
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_IDLE;
         rr_ptr_q   <= '0;
         fifo_wr_q  <= 1'b0;
         fifo_din_q <= '0;
         fifo_src_q <= '0;
         wr_cnt_q   <= '0;
         ovf_err_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         fifo_wr_q <= xfer;
         if (xfer) begin
            fifo_din_q <= src_meta_i[gnt_idx*META_W +: META_W];
            fifo_src_q <= gnt_idx;
            rr_ptr_q   <= rr_ptr_d;
         end
         if (fifo_wr_q && (wr_cnt_q != '1)) wr_cnt_q <= wr_cnt_q + CNT_NBITS'(1);
         if (fifo_wr_q && fifo_full_i)      ovf_err_q <= 1'b1;
      end
   end

   assign fifo_wr_o  = fifo_wr_q;
   assign fifo_din_o = fifo_din_q;
   assign fifo_src_o = fifo_src_q;
   assign idle_o     = (state_q == ST_IDLE);
   assign wr_cnt_o   = wr_cnt_q;
   assign ovf_err_o  = ovf_err_q;

endmodule

// File: tb/tb_piarb_asa_wr.sv
// Directed bench for piarb_asa_wr driving the real sfifo_piarb_asa sink.
module tb_piarb_asa_wr;
   import piarb_asa_wr_pkg::*;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               en;
   logic [3:0]         src_valid;
   logic [4*META_W-1:0] src_meta;
   logic [3:0]         src_ready;
   logic               fifo_full, fifo_fullm1, fifo_empty;
   logic               full_dut, force_full;
   logic               fifo_wr;
   logic [META_W-1:0]  fifo_din, fifo_dout;
   logic [1:0]         fifo_src;
   logic               idle;
   logic [31:0]        wr_cnt;
   logic               ovf_err;
   logic               rd;
   logic [3:0]         fifo_cnt;

   int checks = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   assign full_dut = fifo_full | force_full;

   piarb_asa_wr #(.NUM_SRC(4), .SRC_NBITS(2), .CNT_NBITS(32)) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .en_i          (en),
      .src_valid_i   (src_valid),
      .src_meta_i    (src_meta),
      .src_ready_o   (src_ready),
      .fifo_full_i   (full_dut),
      .fifo_fullm1_i (fifo_fullm1),
      .fifo_wr_o     (fifo_wr),
      .fifo_din_o    (fifo_din),
      .fifo_src_o    (fifo_src),
      .idle_o        (idle),
      .wr_cnt_o      (wr_cnt),
      .ovf_err_o     (ovf_err)
   );

   sfifo_piarb_asa #(.DEPTH_NBITS(3)) u_fifo (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .wr_i     (fifo_wr),
      .din_i    (fifo_din),
      .rd_i     (rd),
      .dout_o   (fifo_dout),
      .full_o   (fifo_full),
      .fullm1_o (fifo_fullm1),
      .empty_o  (fifo_empty),
      .cnt_o    (fifo_cnt)
   );

   function automatic logic [META_W-1:0] meta(input int i);
      return 16'hA000 | 16'(i * 16'h0111);
   endfunction

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      en = 0; src_valid = 0; rd = 0; force_full = 0;
      rst_n = 0; #2; rst_n = 1;
   endtask

   task automatic test_reset();
      rst_n = 0; en = 0; src_valid = 0; rd = 0; force_full = 0;
      #1;
      checks++; if (fifo_wr !== 1'b0)    begin fails++; $display("FAIL reset_wr got=%b exp=0", fifo_wr); end
      checks++; if (fifo_din !== '0)     begin fails++; $display("FAIL reset_din got=%h exp=0", fifo_din); end
      checks++; if (fifo_src !== 2'd0)   begin fails++; $display("FAIL reset_src got=%0d exp=0", fifo_src); end
      checks++; if (idle !== 1'b1)       begin fails++; $display("FAIL reset_idle got=%b exp=1", idle); end
      checks++; if (wr_cnt !== 32'd0)    begin fails++; $display("FAIL reset_cnt got=%0d exp=0", wr_cnt); end
      checks++; if (ovf_err !== 1'b0)    begin fails++; $display("FAIL reset_ovf got=%b exp=0", ovf_err); end
      checks++; if (src_ready !== 4'b0)  begin fails++; $display("FAIL reset_ready got=%b exp=0000", src_ready); end
      checks++; if (fifo_empty !== 1'b1) begin fails++; $display("FAIL reset_empty got=%b exp=1", fifo_empty); end
      #1; rst_n = 1;
   endtask

   task automatic test_alternate();
      logic [1:0] es;
      logic [3:0] er;
      do_reset();
      rd = 1; en = 1; src_valid = 4'b0101;
      step();
      checks++; if (src_ready !== 4'b0001) begin fails++; $display("FAIL alt_first_ready got=%b exp=0001", src_ready); end
      checks++; if (fifo_wr !== 1'b0)      begin fails++; $display("FAIL alt_first_wr got=%b exp=0", fifo_wr); end
      for (int k = 0; k < 4; k++) begin
         step();
         es = (k % 2 == 0) ? 2'd0 : 2'd2;
         er = (k % 2 == 0) ? 4'b0100 : 4'b0001;
         checks++; if (fifo_wr !== 1'b1)      begin fails++; $display("FAIL alt_wr[%0d] got=%b exp=1", k, fifo_wr); end
         checks++; if (fifo_src !== es)       begin fails++; $display("FAIL alt_src[%0d] got=%0d exp=%0d", k, fifo_src, es); end
         checks++; if (fifo_din !== meta(int'(es))) begin fails++; $display("FAIL alt_din[%0d] got=%h exp=%h", k, fifo_din, meta(int'(es))); end
         checks++; if (src_ready !== er)      begin fails++; $display("FAIL alt_ready[%0d] got=%b exp=%b", k, src_ready, er); end
      end
      src_valid = 0;
      step();
      checks++; if (fifo_wr !== 1'b0)  begin fails++; $display("FAIL alt_stop_wr got=%b exp=0", fifo_wr); end
      checks++; if (wr_cnt !== 32'd4)  begin fails++; $display("FAIL alt_cnt got=%0d exp=4", wr_cnt); end
   endtask

   task automatic test_fill();
      int nwr = 0;
      bit saw = 0;
      do_reset();
      rd = 0; en = 1; src_valid = 4'b1111;
      for (int c = 0; c < 20; c++) begin
         step();
         if (fifo_wr) begin
            checks++; if (fifo_src !== 2'(nwr % 4)) begin fails++; $display("FAIL fill_src[%0d] got=%0d exp=%0d", nwr, fifo_src, nwr % 4); end
            nwr++;
         end
         if (fifo_fullm1 && fifo_wr) begin
            saw = 1;
            checks++; if (src_ready !== 4'b0) begin fails++; $display("FAIL fullm1_block got=%b exp=0000", src_ready); end
         end
      end
      checks++; if (nwr != 8)          begin fails++; $display("FAIL fill_writes got=%0d exp=8", nwr); end
      checks++; if (fifo_cnt !== 4'd8) begin fails++; $display("FAIL fill_level got=%0d exp=8", fifo_cnt); end
      checks++; if (src_ready !== 4'b0) begin fails++; $display("FAIL fill_ready got=%b exp=0000", src_ready); end
      checks++; if (ovf_err !== 1'b0)  begin fails++; $display("FAIL fill_ovf got=%b exp=0", ovf_err); end
      checks++; if (wr_cnt !== 32'd8)  begin fails++; $display("FAIL fill_cnt got=%0d exp=8", wr_cnt); end
      checks++; if (!saw)              begin fails++; $display("FAIL fullm1_seen got=0 exp=1"); end
   endtask

   task automatic test_read_one();
      int nw = 0;
      rd = 1;
      step();
      rd = 0;
      for (int c = 0; c < 6; c++) begin
         step();
         if (fifo_wr) begin
            nw++;
            checks++; if (fifo_src !== 2'd0) begin fails++; $display("FAIL rd1_src got=%0d exp=0", fifo_src); end
         end
      end
      checks++; if (nw != 1)           begin fails++; $display("FAIL rd1_grants got=%0d exp=1", nw); end
      checks++; if (fifo_cnt !== 4'd8) begin fails++; $display("FAIL rd1_level got=%0d exp=8", fifo_cnt); end
   endtask

   task automatic test_en_drop();
      int nw = 0;
      int idle_at = -1;
      logic [1:0] last = 2'd0;
      bit resumed = 0;
      do_reset();
      rd = 1; en = 1; src_valid = 4'b1111;
      step(); step(); step();
      en = 0;
      for (int c = 0; c < 6; c++) begin
         step();
         if (fifo_wr) begin nw++; last = fifo_src; end
         if (idle && idle_at < 0) idle_at = c;
      end
      checks++; if (nw != 1)          begin fails++; $display("FAIL drop_writes got=%0d exp=1", nw); end
      checks++; if (last !== 2'd2)    begin fails++; $display("FAIL drop_last_src got=%0d exp=2", last); end
      checks++; if (idle_at < 0 || idle_at > 3) begin fails++; $display("FAIL drop_idle got_cycle=%0d exp<=3", idle_at); end
      en = 1;
      for (int c = 0; c < 6 && !resumed; c++) begin
         step();
         if (fifo_wr) begin
            resumed = 1;
            checks++; if (fifo_src !== 2'd3) begin fails++; $display("FAIL resume_src got=%0d exp=3", fifo_src); end
         end
      end
      checks++; if (!resumed) begin fails++; $display("FAIL resume_timeout got=0 exp=1"); end
   endtask

   task automatic test_ovf();
      do_reset();
      rd = 1; en = 1; src_valid = 4'b0001;
      step(); step();
      checks++; if (fifo_wr !== 1'b1) begin fails++; $display("FAIL ovf_wr got=%b exp=1", fifo_wr); end
      checks++; if (ovf_err !== 1'b0) begin fails++; $display("FAIL ovf_pre got=%b exp=0", ovf_err); end
      force_full = 1; src_valid = 0;
      step();
      checks++; if (ovf_err !== 1'b1) begin fails++; $display("FAIL ovf_set got=%b exp=1", ovf_err); end
      force_full = 0;
      step(); step();
      checks++; if (ovf_err !== 1'b1) begin fails++; $display("FAIL ovf_sticky got=%b exp=1", ovf_err); end
      rst_n = 0; #1;
      checks++; if (ovf_err !== 1'b0) begin fails++; $display("FAIL ovf_clear got=%b exp=0", ovf_err); end
      rst_n = 1;
   endtask

   task automatic test_reset_midflight();
      do_reset();
      rd = 1; en = 1; src_valid = 4'b1111;
      step(); step(); step();
      checks++; if (fifo_wr !== 1'b1) begin fails++; $display("FAIL mid_wr_pre got=%b exp=1", fifo_wr); end
      checks++; if (wr_cnt !== 32'd1) begin fails++; $display("FAIL mid_cnt_pre got=%0d exp=1", wr_cnt); end
      rst_n = 0; src_valid = 4'b1010;
      #1;
      checks++; if (fifo_wr !== 1'b0)   begin fails++; $display("FAIL mid_wr_abort got=%b exp=0", fifo_wr); end
      checks++; if (wr_cnt !== 32'd0)   begin fails++; $display("FAIL mid_cnt_clr got=%0d exp=0", wr_cnt); end
      checks++; if (idle !== 1'b1)      begin fails++; $display("FAIL mid_idle got=%b exp=1", idle); end
      checks++; if (src_ready !== 4'b0) begin fails++; $display("FAIL mid_ready got=%b exp=0000", src_ready); end
      #1; rst_n = 1;
      step();
      checks++; if (src_ready !== 4'b0010) begin fails++; $display("FAIL post_ready got=%b exp=0010", src_ready); end
      step();
      checks++; if (fifo_wr !== 1'b1)  begin fails++; $display("FAIL post_wr got=%b exp=1", fifo_wr); end
      checks++; if (fifo_src !== 2'd1) begin fails++; $display("FAIL post_src got=%0d exp=1", fifo_src); end
   endtask

   initial begin
      src_meta = {meta(3), meta(2), meta(1), meta(0)};
      test_reset();
      test_alternate();
      test_fill();
      test_read_one();
      test_en_drop();
      test_ovf();
      test_reset_midflight();
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
